// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   ALU control-and-execute stage. Decodes alu_op/funct into a 3-bit op,
//   executes single-cycle ops in one cycle, and runs MUL as an iterative
//   shift-add over WIDTH cycles. Result and flags are registered behind a
//   valid/ready handshake.
//
// Ports
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_in_valid/o_in_ready  issue handshake
//   i_alu_op, i_funct      main-decoder class and function field
//   i_a, i_b               operands
//   o_out_valid/i_out_ready result handshake
//   o_result               registered result
//   o_zero/o_neg/o_carry/o_illegal  registered flags
//   o_busy                 multiplier iterating
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 4,
    parameter int MUL_EN  = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [1:0]         i_alu_op,
    input  logic [FUNCT_W-1:0] i_funct,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_zero,
    output logic               o_neg,
    output logic               o_carry,
    output logic               o_illegal,
    output logic               o_busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                           OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_MUL = 3'd7;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
    logic [SHW-1:0]   r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_neg, r_carry, r_illegal;

    logic             w_funct_hi;
    logic [2:0]       w_op;
    logic             w_dec_ill;
    logic [WIDTH:0]   w_sum, w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_carry;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_accept, w_start_mul, w_load;
    logic [WIDTH-1:0] w_ld_res;
    logic             w_ld_carry, w_ld_ill;

    // funct >= 8 means any bit above [2:0] is set; a 3-bit funct can't reach it.
    generate
        if (FUNCT_W > 3) begin : g_hi
            assign w_funct_hi = |i_funct[FUNCT_W-1:3];
        end else begin : g_nohi
            assign w_funct_hi = 1'b0;
        end
    endgenerate

    always_comb begin
        w_op      = OP_ADD;
        w_dec_ill = 1'b0;
        case (i_alu_op)
            2'b11: w_op = OP_ADD;
            2'b10: w_op = OP_XOR;
            2'b01: w_op = OP_SUB;
            default: begin
                if (w_funct_hi) begin
                    w_op      = OP_ADD;
                    w_dec_ill = 1'b1;
                end else begin
                    w_op = i_funct[2:0];
                end
            end
        endcase
        if (w_op == OP_MUL && MUL_EN == 0) begin
            w_op      = OP_ADD;
            w_dec_ill = 1'b1;
        end
    end

    // Extra top bit is carry-out for ADD and borrow for SUB.
    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (w_op)
            OP_ADD: begin w_alu_res = w_sum[WIDTH-1:0];  w_alu_carry = w_sum[WIDTH];  end
            OP_SUB: begin w_alu_res = w_diff[WIDTH-1:0]; w_alu_carry = w_diff[WIDTH]; end
            OP_AND: w_alu_res = i_a & i_b;
            OP_OR:  w_alu_res = i_a | i_b;
            OP_XOR: w_alu_res = i_a ^ i_b;
            OP_SLL: w_alu_res = i_a << w_shamt;
            OP_SRL: w_alu_res = i_a >> w_shamt;
            default: w_alu_res = '0;   // MUL goes through the iterative path
        endcase
    end

    assign w_acc_nxt = r_acc + (r_mplier[r_cnt] ? (r_mcand << r_cnt) : '0);

    assign o_in_ready = i_rst_n && (r_state == S_IDLE) && (!r_out_valid || i_out_ready);
    assign w_accept   = i_in_valid && o_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_start_mul = 1'b0;
        w_load      = 1'b0;
        w_ld_res    = w_alu_res;
        w_ld_carry  = 1'b0;
        w_ld_ill    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_op == OP_MUL) begin
                        w_start_mul = 1'b1;
                        w_state_nxt = S_MUL;
                    end else begin
                        w_load     = 1'b1;
                        w_ld_carry = w_alu_carry;
                        w_ld_ill   = w_dec_ill;
                    end
                end
            end
            S_MUL: begin
                // The last partial product is folded in on the loading edge.
                if (r_cnt == CNT_LAST) begin
                    w_load      = 1'b1;
                    w_ld_res    = w_acc_nxt;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_carry     <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_mul) begin
                r_mcand  <= i_a;
                r_mplier <= i_b;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == S_MUL) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 1'b1;   // wraps back to 0 on completion
            end
            // A load always wins over the consumer draining the old result.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_result    <= w_ld_res;
                r_zero      <= (w_ld_res == '0);
                r_neg       <= w_ld_res[WIDTH-1];
                r_carry     <= w_ld_carry;
                r_illegal   <= w_ld_ill;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_zero      = r_zero;
    assign o_neg       = r_neg;
    assign o_carry     = r_carry;
    assign o_illegal   = r_illegal;
    assign o_busy      = (r_state == S_MUL);
endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    localparam int W = 8;
    localparam int MASK = (1 << W) - 1;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, out_ready;
    logic [1:0] alu_op;
    logic [3:0] funct;
    logic [W-1:0] a, b;

    logic         in_ready, out_valid, zero, neg, carry, illegal, busy;
    logic [W-1:0] result;
    logic         in_ready0, out_valid0, zero0, neg0, carry0, illegal0, busy0;
    logic [W-1:0] result0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W), .FUNCT_W(4), .MUL_EN(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_alu_op(alu_op), .i_funct(funct), .i_a(a), .i_b(b),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_result(result),
        .o_zero(zero), .o_neg(neg), .o_carry(carry), .o_illegal(illegal), .o_busy(busy));

    alu_exec_unit #(.WIDTH(W), .FUNCT_W(4), .MUL_EN(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready0),
        .i_alu_op(alu_op), .i_funct(funct), .i_a(a), .i_b(b),
        .o_out_valid(out_valid0), .i_out_ready(out_ready), .o_result(result0),
        .o_zero(zero0), .o_neg(neg0), .o_carry(carry0), .o_illegal(illegal0), .o_busy(busy0));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference semantics straight from the operation table.
    task automatic ref_calc(input int op2, input int f, input int x, input int y, input bit mul_en,
                            output int r, output bit z, output bit n, output bit c,
                            output bit il, output bit is_mul);
        int op;
        il = 0; c = 0; is_mul = 0;
        if (op2 == 3) op = 0;
        else if (op2 == 2) op = 4;
        else if (op2 == 1) op = 1;
        else if (f < 8) op = f;
        else begin op = 0; il = 1; end
        if (op == 7 && !mul_en) begin op = 0; il = 1; end
        case (op)
            0: begin r = (x + y) & MASK; c = (x + y) > MASK; end
            1: begin r = (x - y) & MASK; c = x < y; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = (x << (y % W)) & MASK;
            6: r = x >> (y % W);
            default: begin r = (x * y) & MASK; is_mul = 1; end
        endcase
        z = (r == 0);
        n = r[W-1];
    endtask

    // Transaction-level model: a result register plus a countdown for MUL.
    bit mdl_on = 0;
    bit m_ov, m_z, m_n, m_c, m_il;
    int m_res, m_left;
    int p_res; bit p_z, p_n, p_c, p_il;

    always @(posedge clk) begin
        int r; bit z, n, c, il, ism, rdy, acc;
        if (!rst_n) begin
            mdl_on = 1; m_ov = 0; m_res = 0; m_z = 0; m_n = 0; m_c = 0; m_il = 0; m_left = 0;
        end else begin
            rdy = (m_left == 0) && (!m_ov || out_ready);
            acc = in_valid && rdy;
            if (m_ov && out_ready) m_ov = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_ov = 1; m_res = p_res; m_z = p_z; m_n = p_n; m_c = p_c; m_il = p_il;
                end
            end
            if (acc) begin
                ref_calc(alu_op, funct, a, b, 1'b1, r, z, n, c, il, ism);
                if (ism) begin
                    m_left = W; p_res = r; p_z = z; p_n = n; p_c = c; p_il = il;
                end else begin
                    m_ov = 1; m_res = r; m_z = z; m_n = n; m_c = c; m_il = il;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("out_valid", out_valid, m_ov);
            chk("result", result, m_res);
            chk("zero", zero, m_z);
            chk("neg", neg, m_n);
            chk("carry", carry, m_c);
            chk("illegal", illegal, m_il);
            chk("busy", busy, m_left > 0);
            chk("in_ready", in_ready, rst_n && m_left == 0 && (!m_ov || out_ready));
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic issue(input int op2, input int f, input int x, input int y);
        in_valid = 1; alu_op = op2[1:0]; funct = f[3:0]; a = x[W-1:0]; b = y[W-1:0];
        tick;
        in_valid = 0;
    endtask

    task automatic run_mul(input int x, input int y, input int exp_r, input bit exp_z, input bit exp_n);
        int cyc = 0;
        issue(0, 7, x, y);
        while (!out_valid && cyc < 20) begin
            chk("mul_busy", busy, 1);
            chk("mul_in_ready", in_ready, 0);
            tick;
            cyc++;
        end
        chk("mul_latency", cyc, W);
        chk("mul_result", result, exp_r);
        chk("mul_zero", zero, exp_z);
        chk("mul_neg", neg, exp_n);
    endtask

    initial begin
        int r; bit z, n, c, il, ism;
        rst_n = 0; in_valid = 0; out_ready = 1; alu_op = 0; funct = 0; a = 0; b = 0;
        tick; tick;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        rst_n = 1;
        #1 chk("post_rst_in_ready", in_ready, 1);

        // Pin the model to hand-computed values.
        ref_calc(0, 0, 'hFF, 'h01, 1'b1, r, z, n, c, il, ism);
        chk("model_add", r, 0); chk("model_add_c", c, 1);
        ref_calc(1, 0, 'h03, 'h05, 1'b1, r, z, n, c, il, ism);
        chk("model_sub", r, 'hFE); chk("model_sub_c", c, 1);
        ref_calc(0, 7, 13, 11, 1'b1, r, z, n, c, il, ism);
        chk("model_mul", r, 'h8F);

        issue(0, 0, 'hFF, 'h01);
        chk("add_res", result, 0); chk("add_zero", zero, 1); chk("add_carry", carry, 1);
        chk("add_neg", neg, 0); chk("add_ill", illegal, 0); chk("add_ov", out_valid, 1);
        issue(1, 0, 'h03, 'h05);
        chk("sub_res", result, 'hFE); chk("sub_carry", carry, 1); chk("sub_neg", neg, 1);
        issue(3, 'hF, 'h01, 'h02);
        chk("op11_res", result, 'h03); chk("op11_ill", illegal, 0);
        issue(0, 'h9, 'h02, 'h03);
        chk("ill_res", result, 'h05); chk("ill_flag", illegal, 1);

        // MUL on the MUL_EN=1 unit; the MUL_EN=0 unit sees the same op as illegal ADD.
        in_valid = 1; alu_op = 0; funct = 7; a = 13; b = 11;
        run_mul(13, 11, 'h8F, 0, 1);
        chk("nomul_res", result0, 'h18);
        chk("nomul_ill", illegal0, 1);
        chk("nomul_busy", busy0, 0);
        run_mul('h10, 'h10, 'h00, 1, 0);

        // Back-pressure: a new request waits while the old result is held.
        issue(0, 3, 'hF0, 'h0F);
        chk("bp_first", result, 'hFF);
        out_ready = 0;
        in_valid = 1; alu_op = 0; funct = 2; a = 'hF0; b = 'h3C;
        repeat (5) begin
            tick;
            chk("bp_hold_res", result, 'hFF);
            chk("bp_hold_ov", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1;
        tick;
        in_valid = 0;
        chk("bp_swap_res", result, 'h30);
        chk("bp_swap_ov", out_valid, 1);

        // Streaming single-cycle ops, first one a shift by 0x0B -> 3.
        issue(0, 5, 'h01, 'h0B);
        chk("sll_b0b", result, 'h08);
        for (int i = 0; i < 15; i++) begin
            in_valid = 1; alu_op = 0;
            funct = 4'($urandom_range(2, 6));
            a = W'($urandom); b = W'($urandom);
            tick;
        end
        in_valid = 0;
        issue(0, 6, 'h80, 'h0B);
        chk("srl_b0b", result, 'h10);

        // Reset at MUL count=4 aborts it.
        issue(0, 7, 13, 11);
        repeat (4) tick;
        rst_n = 0;
        tick;
        chk("abort_ov", out_valid, 0); chk("abort_busy", busy, 0);
        chk("abort_res", result, 0); chk("abort_neg", neg, 0);
        rst_n = 1;
        repeat (10) tick;
        chk("abort_no_result", out_valid, 0);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            in_valid = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            alu_op = 2'($urandom);
            funct = 4'($urandom);
            a = W'($urandom); b = W'($urandom);
            tick;
        end
        rst_n = 1; in_valid = 0; out_ready = 1;
        repeat (12) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised ALU control-and-execute stage for the unicycle/pipelined datapath. It decodes `alu_op`/`funct` into an internal operation code and executes it on WIDTH-bit operands. It registers the result and flags behind a valid/ready handshake. Single-cycle operations complete with 1-cycle latency at full throughput; an optional iterative shift-add multiplier takes WIDTH cycles and back-pressures the issue stage while busy.

## Interface
Parameters:
- WIDTH, 32, operand/result width (≥4, power of 2)
- FUNCT_W, 4, width of `funct` field (≥3)
- MUL_EN, 1, 1 = multiply supported; 0 = op 7 treated as illegal

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- alu_op  in  2  main-decoder ALU class
- funct  in  FUNCT_W  function field
- a, b  in  WIDTH each  operands
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- zero, neg, carry, illegal  out  1 each  registered flags
- busy  out  1  multiplier iterating

## Operation
- Decode, combinational on accepted inputs, priority top-down:
  - alu_op=11 → ADD(0)
  - alu_op=10 → XOR(4)
  - alu_op=01 → SUB(1)
  - alu_op=00 with funct<8 → op=funct[2:0]
  - alu_op=00 with funct≥8 → ADD, illegal=1
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL.
- MUL with MUL_EN=0 → ADD, illegal=1.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: carry = carry-out.
  - SUB: a−b; carry = borrow (1 iff a<b unsigned).
  - Shift amount = b[log2(WIDTH)−1:0]; upper bits of b ignored.
  - MUL: low WIDTH bits of unsigned product.
  - carry = 0 for every op except ADD and SUB.
- Flags: zero = (result==0); neg = result[WIDTH−1]; illegal as decoded. All flags are registered with result.
- FSM states:
  - IDLE: accept when in_valid && in_ready. Non-MUL op → result/flags loaded, out_valid=1, stay IDLE. MUL → latch a, b; clear accumulator; count=0; go MUL.
  - MUL: each cycle, if multiplier bit[count]=1 add shifted multiplicand to accumulator; count++. On the cycle count reaches WIDTH−1, load result/flags, set out_valid=1, go IDLE. MUL ignores in_valid.
- in_ready = rst_n && state==IDLE && (!out_valid || out_ready).
- out_valid clears on out_ready unless a new result loads in the same cycle; load wins.
- result/flags are stable while out_valid && !out_ready.
- busy = (state==MUL).

## Timing
- Reset (rst_n=0 at edge): state=IDLE, count=0, out_valid=0, result=0, zero=0, neg=0, carry=0, illegal=0, busy=0. in_ready=0 while rst_n=0.
- Reset mid-MUL aborts: partial product discarded, no out_valid.
- Single-cycle op accepted at edge E0: out_valid=1 and result visible after E0 (latency 1).
- Back-to-back issue each cycle when out_ready=1 (throughput 1/cycle).
- MUL accepted at E0: busy=1 after E0; result and out_valid after E_WIDTH (latency WIDTH). in_ready=0 during E1..E_WIDTH−1.
- A completed MUL result waits in the registers while out_ready=0; no result is ever overwritten before handshake.
- Simultaneous out_ready=1 and new accept in IDLE: old result leaves, new result loads at the same edge.

## Test plan
- WIDTH=8, alu_op=00, funct=0000, a=FF, b=01 → one cycle later result=00, zero=1, carry=1, neg=0, illegal=0.
- alu_op=01, a=03, b=05 → result=FE, carry=1, neg=1. Then alu_op=11 with funct=1111 → ADD, illegal=0. Then alu_op=00, funct=1001, a=02, b=03 → result=05, illegal=1.
- MUL: alu_op=00, funct=0111, a=13, b=11 (decimal) → busy for 8 cycles, in_ready=0 during, result=8F after edge 8, neg=1. Repeat with a=10h, b=10h → result=00, zero=1.
- Back-pressure: out_ready=0 for 5 cycles after a single-cycle result → result stable, in_ready=0; then out_ready=1 with in_valid=1 → old result consumed and new one loaded the same edge, no gap.
- Streaming 16 ops (SLL/SRL with b=0B treated as shift 3, AND/OR/XOR) with out_ready=1 → one result per cycle, in order, matching the reference model.
- rst_n=0 for 1 cycle at MUL count=4 → all outputs reset values next cycle, no out_valid; MUL_EN=0 build with funct=0111 → ADD result, illegal=1.
